// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//   Up/down LED counter driven by three push buttons. Each button is
//   synchronised, debounced and edge-detected into a single-cycle press
//   event. A small FSM (IDLE/UP/DOWN/PAUSE) selects the count direction, and
//   a free-running divider produces the count tick.
//
// Parameters
//   DIV  iCLK cycles per count tick (>= 2)
//   DEB  iCLK cycles a button must be stable before it is accepted (>= 1)
//
// Ports
//   iCLK     system clock, rising edge
//   iRESETn  asynchronous active-low reset
//   iUP      count-up button, active-low, asynchronous
//   iDOWN    count-down button, active-low, asynchronous
//   iPAUSE   pause/resume button, active-low, asynchronous
//   oLED     current count value
//   oSTATE   current FSM state (IDLE=00, UP=01, DOWN=10, PAUSE=11)
//   oTICK    one-cycle count-tick strobe
//
// Build option
//   LED_SEQ_SAT_EN  when defined, the count saturates at 8'hFF / 8'h00
//                   instead of wrapping modulo 256.
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter int unsigned DIV = 50000000,
    parameter int unsigned DEB = 500000
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic       iUP,
    input  logic       iDOWN,
    input  logic       iPAUSE,
    output logic [7:0] oLED,
    output logic [1:0] oSTATE,
    output logic       oTICK
);

    localparam int unsigned TW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned DW = $clog2(DEB + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        UP    = 2'b01,
        DOWN  = 2'b10,
        PAUSE = 2'b11
    } state_t;

    // Button bundle order: [0] up, [1] down, [2] pause
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb_lvl;
    logic [2:0]    deb_prev;
    logic [2:0]    armed;
    logic [1:0]    sync_ok;
    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    press;

    logic [TW-1:0] tick_cnt;

    state_t        state;
    state_t        dir;
    logic [7:0]    led;
    logic [7:0]    led_inc;
    logic [7:0]    led_dec;

    logic          up_ev;
    logic          dn_ev;
    logic          pa_ev;

    assign btn_raw = {iPAUSE, iDOWN, iUP};

    // -----------------------------------------------------------------------
    // Synchroniser + debouncer + press detection
    // -----------------------------------------------------------------------
    // sync_ok marks the point where sync2 first carries a real sample of the
    // pins rather than its reset value. A button only becomes armed once it
    // has been seen released after that point, so a button held down across
    // reset release cannot produce a press when its debounced level falls.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            sync1    <= '1;
            sync2    <= '1;
            deb_lvl  <= '1;
            deb_prev <= '1;
            armed    <= '0;
            sync_ok  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            deb_prev <= deb_lvl;
            sync_ok  <= {sync_ok[0], 1'b1};
            armed    <= armed | ({3{sync_ok[1]}} & sync2);
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != deb_lvl[i]) begin
                    // Level flips on the DEB-th consecutive differing cycle
                    if (deb_cnt[i] == DW'(DEB - 1)) begin
                        deb_lvl[i] <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = armed & deb_prev & ~deb_lvl;
    assign up_ev = press[0];
    assign dn_ev = press[1];
    assign pa_ev = press[2];

    // -----------------------------------------------------------------------
    // Tick divider: counts 0..DIV-1. oTICK is registered one cycle early so
    // that it is high exactly while the counter holds DIV-1.
    // -----------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            tick_cnt <= '0;
            oTICK    <= 1'b0;
        end else begin
            if (tick_cnt == TW'(DIV - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            oTICK <= (tick_cnt == TW'(DIV - 2));
        end
    end

    // -----------------------------------------------------------------------
    // Count step
    // -----------------------------------------------------------------------
`ifdef LED_SEQ_SAT_EN
    assign led_inc = (led == 8'hFF) ? led : led + 8'd1;
    assign led_dec = (led == 8'h00) ? led : led - 8'd1;
`else
    assign led_inc = led + 8'd1;
    assign led_dec = led - 8'd1;
`endif

    // -----------------------------------------------------------------------
    // FSM and count register. The count step is taken from the current
    // (pre-transition) state; the simultaneous up+down clear overrides it.
    // -----------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state <= IDLE;
            dir   <= UP;
            led   <= '0;
        end else if (up_ev && dn_ev) begin
            state <= IDLE;
            led   <= '0;
        end else begin
            if (oTICK) begin
                case (state)
                    UP:      led <= led_inc;
                    DOWN:    led <= led_dec;
                    default: led <= led;
                endcase
            end
            if (up_ev) begin
                state <= UP;
            end else if (dn_ev) begin
                state <= DOWN;
            end else if (pa_ev) begin
                case (state)
                    UP, DOWN: begin
                        dir   <= state;
                        state <= PAUSE;
                    end
                    PAUSE:   state <= dir;
                    default: state <= state;
                endcase
            end
        end
    end

    assign oLED   = led;
    assign oSTATE = state;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50000000, which sets the number of iCLK cycles per count tick (DIV >= 2).
REQ-002 The block SHALL have parameter DEB, default 500000, which sets the number of iCLK cycles a button must be stable before it is accepted (DEB >= 1).
REQ-003 The block SHALL have port iCLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port iRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port iUP, input, 1 bit: count-up button, active-low, asynchronous to iCLK.
REQ-006 The block SHALL have port iDOWN, input, 1 bit: count-down button, active-low, asynchronous to iCLK.
REQ-007 The block SHALL have port iPAUSE, input, 1 bit: pause/resume button, active-low, asynchronous to iCLK.
REQ-008 The block SHALL have port oLED, output, 8 bits: the current count value driven to the LEDs.
REQ-009 The block SHALL have port oSTATE, output, 2 bits: the current FSM state encoding.
REQ-010 The block SHALL have port oTICK, output, 1 bit: a one-cycle count-tick strobe.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, and then a debouncer that changes its level only after the synchronized input differs from it for DEB consecutive cycles.
REQ-012 A press event SHALL be a single-cycle pulse generated on the 1->0 transition of a debounced level; releases generate no event.
REQ-013 A raw button edge held stable SHALL produce its press event no later than DEB+3 cycles after the edge; glitches shorter than DEB cycles SHALL produce no event.
REQ-014 The tick counter SHALL run freely from 0 to DIV-1 and wrap; oTICK SHALL be 1 in exactly the cycle where the counter equals DIV-1.
REQ-015 The FSM state encodings SHALL be IDLE=00, UP=01, DOWN=10 and PAUSE=11, and oSTATE SHALL equal the registered state.
REQ-016 UP and DOWN press events in the same cycle SHALL cause a transition to IDLE from any state, and this rule SHALL take priority over all others.
REQ-017 Otherwise, an UP event SHALL go to UP and a DOWN event SHALL go to DOWN from any state, with UP taking priority over DOWN, and DOWN over PAUSE.
REQ-018 A PAUSE event in UP or DOWN SHALL go to PAUSE and store that direction; a PAUSE event in PAUSE SHALL resume the stored direction; a PAUSE event in IDLE SHALL be ignored.
REQ-019 The state transition SHALL take effect on the clock edge following the cycle in which the event is high.
REQ-020 oLED SHALL change only in a tick cycle, except that it SHALL clear on the IDLE transition.
REQ-021 In UP, oLED SHALL become oLED+1 at the tick, and in DOWN it SHALL become oLED-1.
REQ-022 In PAUSE oLED SHALL hold its value; in IDLE oLED SHALL be 0.
REQ-023 When an event and a tick occur in the same cycle, the count step SHALL use the pre-transition state.
REQ-024 When the IDLE transition and a tick occur in the same cycle, oLED SHALL become 0.
REQ-025 Without the macro, oLED SHALL wrap modulo 256, so that 8'hFF+1 gives 8'h00 and 8'h00-1 gives 8'hFF.

Reset
REQ-026 While iRESETn=0 (asynchronously), state SHALL be IDLE, oSTATE=00, oLED=8'h00, oTICK=0, the tick counter 0, and the stored direction UP.
REQ-027 While iRESETn=0, synchronizer flops and debounced levels SHALL be 1 (released), so that a button held through reset release produces no press event.
REQ-028 Reset asserted mid-count or mid-debounce SHALL abort all activity; after release the tick counter SHALL restart at 0.

Configuration
REQ-029 When the macro LED_SEQ_SAT_EN is defined, oLED SHALL saturate: UP SHALL hold 8'hFF and DOWN SHALL hold 8'h00 at the respective limit, with the state unchanged.
REQ-030 When LED_SEQ_SAT_EN is undefined, oLED SHALL wrap as in REQ-025; no other behaviour SHALL differ.

Verification (DIV=4, DEB=3)
REQ-031 The bench SHALL check: reset release with all buttons high, run 40 cycles -> oSTATE=00, oLED=00, and oTICK pulses every 4th cycle.
REQ-032 The bench SHALL check: iUP low for 10 cycles, then high -> exactly one event, oSTATE=01, and oLED increments by 1 per oTICK; a 2-cycle iDOWN glitch produces no change.
REQ-033 The bench SHALL check: from UP at oLED=05, press iPAUSE -> oSTATE=11 and oLED holds 05 across 5 ticks; press iPAUSE again -> oSTATE=01 and counting resumes at 06.
REQ-034 The bench SHALL check: DOWN from oLED=01 -> 00 then FF (wrap), or 00 held with LED_SEQ_SAT_EN defined; likewise UP at FF -> 00, or FF held.
REQ-035 The bench SHALL check: iUP and iDOWN falling in the same cycle while in DOWN at oLED=3C -> IDLE, oLED=00; then iRESETn pulsed low mid-tick -> all outputs 0 immediately.
